segment_descriptor_loader: RTL and testbench

// Loads segment registers (MOV/POP Sreg, far JMP/CALL target) and writes selector plus 64-bit descriptor into the segment register file.
// The segmentation unit consumes that register file to do its checks.

---
 rtl/segment_descriptor_loader_pkg.sv | 41 ++++
 rtl/segment_descriptor_loader_if.sv | 20 ++
 rtl/segment_descriptor_loader_decode.sv | 31 +++
 rtl/segment_descriptor_loader.sv | 218 +++++++++++++++++++++
 tb/tb_segment_descriptor_loader.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/segment_descriptor_loader_pkg.sv
// Shared types and constants for the segment descriptor loader.
// Segment index enum, descriptor bit positions, fault vectors, FSM states.
package segment_pkg;

    typedef enum logic [2:0] {
        SEG_CS = 3'd0,
        SEG_SS = 3'd1,
        SEG_DS = 3'd2,
        SEG_ES = 3'd3,
        SEG_FS = 3'd4,
        SEG_GS = 3'd5
    } seg_index_e;

    localparam int DESC_P       = 47;
    localparam int DESC_DPL_HI  = 46;
    localparam int DESC_DPL_LO  = 45;
    localparam int DESC_S       = 44;
    localparam int DESC_TYPE_HI = 43;
    localparam int DESC_TYPE_LO = 40;
    localparam int DESC_ACC     = 40;

    localparam logic [7:0] VEC_NP = 8'd11;
    localparam logic [7:0] VEC_SS = 8'd12;
    localparam logic [7:0] VEC_GP = 8'd13;

    typedef logic [2:0] ld_state_t;
    localparam ld_state_t ST_IDLE      = 3'd0;
    localparam ld_state_t ST_READ_LO   = 3'd1;
    localparam ld_state_t ST_READ_HI   = 3'd2;
    localparam ld_state_t ST_CHECK     = 3'd3;
    localparam ld_state_t ST_WRITE_ACC = 3'd4;
    localparam ld_state_t ST_COMMIT    = 3'd5;
    localparam ld_state_t ST_FAULT     = 3'd6;

    // Real-mode descriptor: base = sel<<4, limit 0xFFFF, present RW
    // accessed data, DPL 0, byte granular.
    function automatic logic [63:0] real_mode_desc(input logic [15:0] sel);
        return {8'h00, 8'h00, 8'h93, 4'h0, sel, 4'h0, 16'hFFFF};
    endfunction

endpackage

// File: rtl/segment_descriptor_loader_if.sv
// Memory port of the descriptor loader (dword reads, Accessed writes).
// master: loader drives req/write/address/wdata; slave: memory answers.
interface segment_descriptor_loader_if;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_write, mem_address, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_write, mem_address, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/segment_descriptor_loader_decode.sv
// Splits a 64-bit segment descriptor into the fields used by load checks.
// In: desc. Out: present, s, dpl, is_code, conforming, readable, writable, accessed.
module segment_descriptor_decode
    import segment_pkg::*;
(
    input  logic [63:0] desc,
    output logic        present,
    output logic        s,
    output logic [1:0]  dpl,
    output logic        is_code,
    output logic        conforming,
    output logic        readable,
    output logic        writable,
    output logic        accessed
);
    logic [3:0] typ;
    logic       unused_fields;

    assign typ        = desc[DESC_TYPE_HI:DESC_TYPE_LO];
    assign present    = desc[DESC_P];
    assign s          = desc[DESC_S];
    assign dpl        = desc[DESC_DPL_HI:DESC_DPL_LO];
    assign is_code    = typ[3];
    assign conforming = typ[3] & typ[2];
    assign readable   = typ[3] & typ[1];
    assign writable   = ~typ[3] & typ[1];
    assign accessed   = desc[DESC_ACC];

    // Base/limit/flags are carried through to the register file untouched.
    assign unused_fields = ^{desc[63:48], desc[39:0]};
endmodule

// File: rtl/segment_descriptor_loader.sv
// Segment register loader: fetches/synthesizes a descriptor, checks it,
// sets Accessed, then commits to the segment register file or faults.
module segment_descriptor_loader
    import segment_pkg::*;
#(
    parameter bit SET_ACCESSED_BIT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_load_valid,
    output logic        o_load_ready,
    input  logic [15:0] i_selector,
    input  logic [2:0]  i_segment_index,
    input  logic        i_protected_mode,
    input  logic [1:0]  i_current_privilege_level,
    input  logic [31:0] i_gdtr_base,
    input  logic [31:0] i_ldtr_base,
    input  logic [15:0] i_gdtr_limit,
    input  logic [15:0] i_ldtr_limit,
    segment_descriptor_loader_if.master mem,
    output logic        o_seg_write_enable,
    output logic [2:0]  o_seg_write_index,
    output logic [15:0] o_seg_selector,
    output logic [63:0] o_seg_descriptor,
    output logic        o_fault_valid,
    output logic [7:0]  o_fault_vector,
    output logic [15:0] o_fault_error_code
);
    ld_state_t   state_q, state_d;
    logic [15:0] sel_q, sel_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  cpl_q, cpl_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] desc_q, desc_d;
    logic [7:0]  vec_q, vec_d;
    logic [15:0] code_q, code_d;

    logic        d_present, d_s, d_code, d_conf;
    logic        d_read, d_write, d_acc;
    logic [1:0]  d_dpl;

    segment_descriptor_decode u_decode (
        .desc       (desc_q),
        .present    (d_present),
        .s          (d_s),
        .dpl        (d_dpl),
        .is_code    (d_code),
        .conforming (d_conf),
        .readable   (d_read),
        .writable   (d_write),
        .accessed   (d_acc)
    );

    logic        in_null, in_limit_bad;
    logic [31:0] tbl_base;
    logic [15:0] tbl_limit;

    assign in_null   = (i_selector[15:2] == 14'd0);
    assign tbl_base  = i_selector[2] ? i_ldtr_base : i_gdtr_base;
    assign tbl_limit = i_selector[2] ? i_ldtr_limit : i_gdtr_limit;
    // 17-bit compare so an index near 0xFFFF cannot wrap past the limit.
    assign in_limit_bad = {1'b0, i_selector[15:3], 3'b111} > {1'b0, tbl_limit};

    logic        chk_fault;
    logic [7:0]  chk_vec;
    logic [15:0] chk_code;
    logic [1:0]  rpl, eff_pl;

    assign rpl    = sel_q[1:0];
    assign eff_pl = (rpl > cpl_q) ? rpl : cpl_q;

    // Priority chain: the first failing check decides the fault.
    always_comb begin
        chk_fault = 1'b0;
        chk_vec   = VEC_GP;
        chk_code  = {sel_q[15:2], 2'b00};
        if (!d_s) begin
            chk_fault = 1'b1;
        end else if (idx_q == SEG_CS) begin
            if (!d_code)
                chk_fault = 1'b1;
            else if (d_conf)
                chk_fault = (d_dpl > cpl_q);
            else
                chk_fault = (d_dpl != cpl_q) || (rpl > cpl_q);
        end else if (idx_q == SEG_SS) begin
            chk_fault = !d_write || (rpl != cpl_q) || (d_dpl != cpl_q);
        end else if (idx_q <= SEG_GS) begin
            if (d_code && !d_read)
                chk_fault = 1'b1;
            else if (!d_conf)
                chk_fault = (eff_pl > d_dpl);
        end
        if (!chk_fault && !d_present) begin
            chk_fault = 1'b1;
            chk_vec   = (idx_q == SEG_SS) ? VEC_SS : VEC_NP;
        end
        if (!chk_fault && idx_q > SEG_GS) begin
            chk_fault = 1'b1;
            chk_code  = 16'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        cpl_d   = cpl_q;
        addr_d  = addr_q;
        desc_d  = desc_q;
        vec_d   = vec_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (i_load_valid) begin
                    sel_d = i_selector;
                    idx_d = i_segment_index;
                    cpl_d = i_current_privilege_level;
                    if (!i_protected_mode) begin
                        desc_d  = real_mode_desc(i_selector);
                        state_d = ST_COMMIT;
                    end else if (in_null) begin
                        if (i_segment_index == SEG_CS ||
                            i_segment_index == SEG_SS) begin
                            vec_d   = VEC_GP;
                            code_d  = 16'd0;
                            state_d = ST_FAULT;
                        end else begin
                            desc_d  = 64'd0;
                            state_d = ST_COMMIT;
                        end
                    end else if (in_limit_bad) begin
                        vec_d   = VEC_GP;
                        code_d  = {i_selector[15:2], 2'b00};
                        state_d = ST_FAULT;
                    end else begin
                        addr_d  = tbl_base +
                                  {16'h0, i_selector[15:3], 3'b000};
                        state_d = ST_READ_LO;
                    end
                end
            end
            ST_READ_LO: begin
                if (mem.mem_ack) begin
                    desc_d[31:0] = mem.mem_rdata;
                    addr_d       = addr_q + 32'd4;
                    state_d      = ST_READ_HI;
                end
            end
            ST_READ_HI: begin
                if (mem.mem_ack) begin
                    desc_d[63:32] = mem.mem_rdata;
                    state_d       = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (chk_fault) begin
                    vec_d   = chk_vec;
                    code_d  = chk_code;
                    state_d = ST_FAULT;
                end else if (SET_ACCESSED_BIT && !d_acc) begin
                    state_d = ST_WRITE_ACC;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_WRITE_ACC: begin
                if (mem.mem_ack) begin
                    desc_d[DESC_ACC] = 1'b1;
                    state_d          = ST_COMMIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            cpl_q   <= '0;
            addr_q  <= '0;
            desc_q  <= '0;
            vec_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            cpl_q   <= cpl_d;
            addr_q  <= addr_d;
            desc_q  <= desc_d;
            vec_q   <= vec_d;
            code_q  <= code_d;
        end
    end

    logic commit, fault;
    assign commit = (state_q == ST_COMMIT);
    assign fault  = (state_q == ST_FAULT);

    assign o_load_ready    = (state_q == ST_IDLE);
    assign mem.mem_req     = (state_q == ST_READ_LO) ||
                             (state_q == ST_READ_HI) ||
                             (state_q == ST_WRITE_ACC);
    assign mem.mem_write   = (state_q == ST_WRITE_ACC);
    assign mem.mem_address = addr_q;
    assign mem.mem_wdata   = mem.mem_write ? (desc_q[63:32] | 32'h100) : 32'd0;

    assign o_seg_write_enable = commit;
    assign o_seg_write_index  = commit ? idx_q : 3'd0;
    assign o_seg_selector     = commit ? sel_q : 16'd0;
    assign o_seg_descriptor   = commit ? desc_q : 64'd0;
    assign o_fault_valid      = fault;
    assign o_fault_vector     = fault ? vec_q : 8'd0;
    assign o_fault_error_code = fault ? code_q : 16'd0;
endmodule

// File: tb/tb_segment_descriptor_loader.sv
// Directed bench for segment_descriptor_loader with a zero-wait memory
// model; each step compares DUT strobes against hand-computed values.
module tb_segment_descriptor_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_load_valid;
    logic        o_load_ready;
    logic [15:0] i_selector;
    logic [2:0]  i_segment_index;
    logic        i_protected_mode;
    logic [1:0]  i_cpl;
    logic [31:0] i_gdtr_base, i_ldtr_base;
    logic [15:0] i_gdtr_limit, i_ldtr_limit;
    logic        seg_we;
    logic [2:0]  seg_idx;
    logic [15:0] seg_sel;
    logic [63:0] seg_desc;
    logic        fault_valid;
    logic [7:0]  fault_vec;
    logic [15:0] fault_code;

    segment_descriptor_loader_if mif ();

    segment_descriptor_loader dut (
        .clock                     (clk),
        .reset                     (reset),
        .i_load_valid              (i_load_valid),
        .o_load_ready              (o_load_ready),
        .i_selector                (i_selector),
        .i_segment_index           (i_segment_index),
        .i_protected_mode          (i_protected_mode),
        .i_current_privilege_level (i_cpl),
        .i_gdtr_base               (i_gdtr_base),
        .i_ldtr_base               (i_ldtr_base),
        .i_gdtr_limit              (i_gdtr_limit),
        .i_ldtr_limit              (i_ldtr_limit),
        .mem                       (mif.master),
        .o_seg_write_enable        (seg_we),
        .o_seg_write_index         (seg_idx),
        .o_seg_selector            (seg_sel),
        .o_seg_descriptor          (seg_desc),
        .o_fault_valid             (fault_valid),
        .o_fault_vector            (fault_vec),
        .o_fault_error_code        (fault_code)
    );

    always #5 clk = ~clk;

    logic [31:0] lo_word, hi_word;
    logic        stall_hi;

    always_comb begin
        mif.mem_ack   = mif.mem_req && (stall_hi ? !mif.mem_address[2] : 1'b1);
        mif.mem_rdata = mif.mem_address[2] ? hi_word : lo_word;
    end

    int          req_cycles = 0;
    int          wr_cnt = 0;
    logic [31:0] lo_addr = '0, hi_addr = '0;
    logic [31:0] wr_addr = '0, wr_data = '0;

    always @(posedge clk) begin
        if (mif.mem_req) req_cycles <= req_cycles + 1;
        if (mif.mem_req && mif.mem_ack) begin
            if (mif.mem_write) begin
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= mif.mem_address;
                wr_data <= mif.mem_wdata;
            end else if (mif.mem_address[2]) begin
                hi_addr <= mif.mem_address;
            end else begin
                lo_addr <= mif.mem_address;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic        g_we, g_fault;
    logic [2:0]  g_idx;
    logic [15:0] g_sel, g_code;
    logic [63:0] g_desc;
    logic [7:0]  g_vec;

    task automatic run_load(input logic pe, input logic [1:0] cpl,
                            input logic [15:0] sel, input logic [2:0] idx,
                            output int lat);
        i_protected_mode = pe;
        i_cpl            = cpl;
        i_selector       = sel;
        i_segment_index  = idx;
        i_load_valid     = 1'b1;
        @(posedge clk); #1;
        i_load_valid = 1'b0;
        lat = 1;
        while (!(seg_we || fault_valid) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        g_we    = seg_we;
        g_fault = fault_valid;
        g_idx   = seg_idx;
        g_sel   = seg_sel;
        g_desc  = seg_desc;
        g_vec   = fault_vec;
        g_code  = fault_code;
        @(posedge clk); #1;
    endtask

    int lat, r0, w0;

    initial begin
        reset = 1'b1;
        i_load_valid = 1'b0;
        i_selector = '0;
        i_segment_index = '0;
        i_protected_mode = 1'b0;
        i_cpl = '0;
        i_gdtr_base = 32'h1000;
        i_gdtr_limit = 16'h00FF;
        i_ldtr_base = 32'h8000;
        i_ldtr_limit = 16'h00FF;
        lo_word = 32'h0000FFFF;
        hi_word = 32'h00CF9300;
        stall_hi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", o_load_ready, 1);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_we", seg_we, 0);
        chk("rst_fault", fault_valid, 0);
        chk("rst_desc", seg_desc, 0);

        // Real mode DS load.
        r0 = req_cycles;
        run_load(1'b0, 2'd0, 16'h1234, 3'd2, lat);
        chk("rm_lat", lat, 1);
        chk("rm_we", g_we, 1);
        chk("rm_idx", g_idx, 2);
        chk("rm_sel", g_sel, 16'h1234);
        chk("rm_desc", g_desc, 64'h0000_9301_2340_FFFF);
        chk("rm_noreq", req_cycles - r0, 0);

        // Protected mode, Accessed already set.
        w0 = wr_cnt;
        run_load(1'b1, 2'd0, 16'h0010, 3'd2, lat);
        chk("pm_lat", lat, 4);
        chk("pm_desc", g_desc, 64'h00CF9300_0000FFFF);
        chk("pm_lo_addr", lo_addr, 32'h1010);
        chk("pm_hi_addr", hi_addr, 32'h1014);
        chk("pm_nowr", wr_cnt - w0, 0);

        // Protected mode, Accessed clear -> write back.
        hi_word = 32'h00CF9200;
        w0 = wr_cnt;
        run_load(1'b1, 2'd0, 16'h0010, 3'd2, lat);
        chk("acc_lat", lat, 5);
        chk("acc_wr", wr_cnt - w0, 1);
        chk("acc_wr_addr", wr_addr, 32'h1014);
        chk("acc_wr_data", wr_data, 32'h00CF9300);
        chk("acc_desc", g_desc, 64'h00CF9300_0000FFFF);

        // Null selectors.
        r0 = req_cycles;
        run_load(1'b1, 2'd0, 16'h0000, 3'd1, lat);
        chk("nul_ss_lat", lat, 1);
        chk("nul_ss_flt", g_fault, 1);
        chk("nul_ss_vec", g_vec, 13);
        chk("nul_ss_code", g_code, 0);
        run_load(1'b1, 2'd0, 16'h0000, 3'd3, lat);
        chk("nul_es_we", g_we, 1);
        chk("nul_es_desc", g_desc, 0);
        chk("nul_noreq", req_cycles - r0, 0);

        // Table limit fault.
        i_gdtr_limit = 16'h0017;
        r0 = req_cycles;
        run_load(1'b1, 2'd0, 16'h0018, 3'd2, lat);
        chk("lim_lat", lat, 1);
        chk("lim_vec", g_vec, 13);
        chk("lim_code", g_code, 16'h0018);
        chk("lim_noreq", req_cycles - r0, 0);
        i_gdtr_limit = 16'h00FF;

        // Not-present data descriptor.
        hi_word = 32'h00CF1300;
        run_load(1'b1, 2'd0, 16'h0010, 3'd1, lat);
        chk("np_ss_vec", g_vec, 12);
        chk("np_ss_code", g_code, 16'h0010);
        run_load(1'b1, 2'd0, 16'h0010, 3'd2, lat);
        chk("np_ds_lat", lat, 4);
        chk("np_ds_vec", g_vec, 11);
        chk("np_ds_code", g_code, 16'h0010);

        // Privilege: CPL3/RPL3 into DPL0 data.
        hi_word = 32'h00CF9300;
        run_load(1'b1, 2'd3, 16'h0013, 3'd2, lat);
        chk("priv_flt", g_fault, 1);
        chk("priv_vec", g_vec, 13);
        chk("priv_code", g_code, 16'h0010);

        // Reset while stalled in READ_HI.
        stall_hi = 1'b1;
        i_protected_mode = 1'b1;
        i_cpl = 2'd0;
        i_selector = 16'h0010;
        i_segment_index = 3'd2;
        i_load_valid = 1'b1;
        @(posedge clk); #1;
        i_load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_req", mif.mem_req, 1);
        chk("stall_addr", mif.mem_address, 32'h1014);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_req", mif.mem_req, 0);
        chk("mid_rst_ready", o_load_ready, 1);
        chk("mid_rst_we", seg_we, 0);
        chk("mid_rst_flt", fault_valid, 0);
        reset = 1'b0;
        stall_hi = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", {seg_we, fault_valid, mif.mem_req}, 0);
        run_load(1'b1, 2'd0, 16'h0010, 3'd2, lat);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_desc", g_desc, 64'h00CF9300_0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
